// File: rtl/wb_writer_pkg.sv
// Shared widths and the queued write-request record for the writeback path.
package wb_writer_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;

    // One pending register-file write: destination register and its value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Request queue for the writeback unit: storage, pointers, occupancy and flush.
// Per-entry valid bits let the top scan queued destinations for hazards.
module wb_fifo
    import wb_writer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  wb_req_t               i_wdata,
    output wb_req_t               o_head,
    output logic [CNT_W-1:0]      o_count,
    output logic [DEPTH-1:0]      o_valid,
    output logic [REG_ADDR_W-1:0] o_regs [DEPTH]
);

    wb_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Flush wins over both push and pop; push is refused when full, pop when empty.
    assign w_push = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    // Entry payload storage; deliberately left unreset, validity lives in r_valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Expose every entry's destination for the hazard comparators.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_regs[i] = r_mem[i].rd;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_valid = r_valid;

endmodule

// File: rtl/wb_writer.sv
// Writeback unit: queues result writes, drains one per cycle into the register
// file through a registered port, and flags registers with a write still pending.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] chk_reg_a,
    input  logic [REG_ADDR_W-1:0] chk_reg_b,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  WE,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData,
    output logic [CNT_W-1:0]      count
);

    wb_req_t               w_req;
    wb_req_t               w_head;
    logic [CNT_W-1:0]      w_count;
    logic [DEPTH-1:0]      w_valid;
    logic [REG_ADDR_W-1:0] w_regs [DEPTH];
    logic                  w_push;
    logic                  w_pop;

    // Ready depends only on state and flush, never on in_valid.
    assign in_ready = (w_count < CNT_W'(DEPTH)) && !flush;
    // Writes to register 0 are accepted but never enter the queue.
    assign w_push   = in_valid && in_ready && (in_reg != '0);
    assign w_pop    = (w_count != '0) && !flush;
    assign w_req    = '{rd: in_reg, data: in_data};
    assign count    = w_count;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .CLR     (CLR),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (w_req),
        .o_head  (w_head),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_regs  (w_regs)
    );

    // Registered register-file port; address/data hold their last value when idle.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            WE        <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (w_pop) begin
            WE        <= 1'b1;
            WriteReg  <= w_head.rd;
            WriteData <= w_head.data;
        end else begin
            WE        <= 1'b0;
        end
    end

    // Hazard probes: a register is busy if queued or currently being written.
    always_comb begin
        busy_a = WE && (WriteReg == chk_reg_a);
        busy_b = WE && (WriteReg == chk_reg_b);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_regs[i] == chk_reg_a)) begin
                busy_a = 1'b1;
            end
            if (w_valid[i] && (w_regs[i] == chk_reg_b)) begin
                busy_b = 1'b1;
            end
        end
        if (chk_reg_a == '0) begin
            busy_a = 1'b0;
        end
        if (chk_reg_b == '0) begin
            busy_b = 1'b0;
        end
    end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write requests (power of two, >=2).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 CLR  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  result request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_reg  input  5  destination register number.
REQ-007 in_data  input  32  result value.
REQ-008 flush  input  1  synchronous discard of all pending requests.
REQ-009 chk_reg_a  input  5  register number probed for pending write (operand A).
REQ-010 chk_reg_b  input  5  register number probed for pending write (operand B).
REQ-011 busy_a  output  1  write to chk_reg_a still pending.
REQ-012 busy_b  output  1  write to chk_reg_b still pending.
REQ-013 WE  output  1  register-file write enable.
REQ-014 WriteReg  output  5  register-file write address.
REQ-015 WriteData  output  32  register-file write data.
REQ-016 count  output  3  requests currently queued (0..DEPTH).

Function
REQ-017 Transfer occurs on rising edge when in_valid=1 and in_ready=1; otherwise inputs ignored.
REQ-018 in_ready = (count < DEPTH) and flush=0; combinational from state, independent of in_valid.
REQ-019 Transfer with in_reg=0 is accepted and dropped: not queued, count unchanged, no WE pulse.
REQ-020 Accepted nonzero requests queued in FIFO order; a register named twice is written twice, in order, last value wins.
REQ-021 Each edge with count>0 and flush=0: head popped, WE=1, WriteReg/WriteData = head contents, all registered; else WE=0.
REQ-022 Latency: request accepted at edge N into empty queue -> WE=1 with its data from edge N+1 to N+2 (one full cycle, spanning the register file's falling-edge sample).
REQ-023 Throughput: one write per cycle; simultaneous push and pop in same edge leaves count unchanged.
REQ-024 Full (count=DEPTH): in_ready=0; pop that edge frees a slot for the next cycle, not the current one.
REQ-025 Empty: WE=0; WriteReg and WriteData hold last values.
REQ-026 flush=1 at an edge: queue emptied, count=0, WE=0 next cycle, input not accepted; flush has priority over push and pop.
REQ-027 busy_a = 1 when chk_reg_a != 0 and matches in_reg of any queued entry or WriteReg while WE=1; busy_b identical for chk_reg_b; purely combinational.
REQ-028 busy_* excludes the not-yet-accepted in_reg on the input port.
REQ-029 Register 0 never reported busy and never written.
REQ-030 Write/read pointers wrap modulo DEPTH; count distinguishes full from empty.

Reset
REQ-031 CLR=0 asynchronously forces WE=0, WriteReg=0, WriteData=0, count=0, pointers=0, all entry-valid state cleared.
REQ-032 During and after reset until first push: in_ready=1, busy_a=busy_b=0.
REQ-033 Reset mid-drain discards all queued requests; no WE pulse after CLR deasserts until a new request is accepted.
REQ-034 FIFO storage data need not be reset; only valid/pointer/count state.

Structure
REQ-035 Shared package holds REG_ADDR_W=5, DATA_W=32, DEPTH default, and the request record (reg, data).
REQ-036 One sub-module wb_fifo (storage, pointers, count, flush); wb_writer adds drop-zero logic, output register and busy comparators.
REQ-037 No latches; one clock domain; no combinational path from in_valid to in_ready.

Verification
REQ-038 Reset then push (r5, 0x1234_5678) at edge 1 -> WE=1, WriteReg=5, WriteData=0x12345678 during cycle 2 only; count returns 0.
REQ-039 Push r3,r7,r3,r9,r11 back-to-back with no pops possible beyond one per cycle -> writes appear in order r3,r7,r3,r9,r11; in_ready never drops when occupancy stays below DEPTH; final r3 value is second one.
REQ-040 Push r0 with 0xFFFF_FFFF -> no WE pulse, count stays 0, busy_a=0 with chk_reg_a=0.
REQ-041 Fill 4 entries while held (in_valid continuous, compare count) -> in_ready=0 at count=4; 5th request accepted one cycle after first pop; order preserved.
REQ-042 Queue r8,r9; chk_reg_a=9, chk_reg_b=8 -> busy_a=busy_b=1; after r8 write cycle busy_b=0, busy_a clears after r9 WE cycle ends.
REQ-043 Queue 3 entries, assert flush one cycle (and separately CLR=0 mid-drain) -> count=0, WE=0 next cycle, no further writes, busy_* =0.
